// File: rtl/mof_source.sv
// mof_source: filtered majority-of-five voter with registered popcount and unanimity flag.
// Define MOF_SYNC_EN to insert a two-flop synchronizer on sw ahead of the popcount register.
module mof_source #(
    parameter int FILTER_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] sw,
    output logic       led,
    output logic [2:0] count,
    output logic       unanimous
);
    localparam logic [3:0] LAST = 4'(FILTER_CYCLES - 1);

    logic [4:0] sampled;
    logic [2:0] pop;
    logic [3:0] stab;
    logic       maj;

`ifdef MOF_SYNC_EN
    logic [4:0] sync1, sync2;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw;
            sync2 <= sync1;
        end
    end
    assign sampled = sync2;
`else
    assign sampled = sw;
`endif

    always_comb begin
        pop = '0;
        for (int i = 0; i < 5; i++) pop = pop + 3'(sampled[i]);
    end

    assign maj       = count >= 3'd3;
    assign unanimous = count == 3'd0 || count == 3'd5;

    // led only moves after maj has disagreed with it for FILTER_CYCLES consecutive edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            led   <= 1'b0;
            stab  <= '0;
        end else begin
            count <= pop;
            if (maj == led) begin
                stab <= '0;
            end else if (stab == LAST) begin
                led  <= maj;
                stab <= '0;
            end else begin
                stab <= stab + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_mof_source.sv
// tb_mof_source: scoreboard bench driving FILTER_CYCLES=4 and FILTER_CYCLES=1 instances in parallel.
// Expected outputs come from a sampling pipeline plus a majority-history window model.
module tb_mof_source;
    localparam int FC = 4;
`ifdef MOF_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    typedef struct {
        logic [2:0] cnt;
        logic       l4;
        logic       l1;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [4:0] sw = 5'b11111;
    logic       led4, led1, un4, un1;
    logic [2:0] cnt4, cnt1;

    exp_t       sb[$];
    logic [2:0] m_cnt;
    logic       m_l4, m_l1;
    logic [FC-1:0] h4;
    logic [4:0] s1, s2;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    mof_source #(.FILTER_CYCLES(FC)) dut4 (
        .clk(clk), .rst_n(rst_n), .sw(sw), .led(led4), .count(cnt4), .unanimous(un4)
    );
    mof_source #(.FILTER_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sw(sw), .led(led1), .count(cnt1), .unanimous(un1)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic logic [2:0] pop5(input logic [4:0] v);
        pop5 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]) + 3'(v[4]);
    endfunction

    task automatic model_reset();
        m_cnt = '0;
        m_l4  = 1'b0;
        m_l1  = 1'b0;
        h4    = '0;
        s1    = '0;
        s2    = '0;
    endtask

    // drive v for one edge (called at negedge), predict, then check after the edge
    task automatic step(input logic [4:0] v);
        exp_t e;
        logic maj;
        sw  = v;
        maj = m_cnt >= 3'd3;
        h4  = {h4[FC-2:0], maj};
        if (h4 == {FC{~m_l4}}) m_l4 = ~m_l4;
        m_l1 = maj;
        if (SYNC) begin
            m_cnt = pop5(s2);
            s2 = s1;
            s1 = v;
        end else begin
            m_cnt = pop5(v);
        end
        e = '{m_cnt, m_l4, m_l1};
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        chk("count4", int'(cnt4), int'(e.cnt));
        chk("count1", int'(cnt1), int'(e.cnt));
        chk("led4", int'(led4), int'(e.l4));
        chk("led1", int'(led1), int'(e.l1));
        chk("unanimous", int'(un4), int'(e.cnt == 3'd0 || e.cnt == 3'd5));
    endtask

    initial begin
        logic [4:0] v;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_count", int'(cnt4), 0);
        chk("rst_led", int'(led4), 0);
        chk("rst_unanimous", int'(un4), 1);
        chk("rst_led1", int'(led1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        for (int p = 0; p < 32; p++) repeat (10) step(5'(p));

        repeat (10) step(5'b00000);
        repeat (8) step(5'b01011);

        repeat (8) step(5'b11111);
        repeat (3) step(5'b00001);
        repeat (6) step(5'b11111);
        chk("glitch_led", int'(led4), 1);
        chk("glitch_stab", int'(dut4.stab), 0);

        repeat (8) step(5'b00000);
        repeat (2) step(5'b11100);
        rst_n = 1'b0;
        #1;
        chk("midrst_count", int'(cnt4), 0);
        chk("midrst_led", int'(led4), 0);
        chk("midrst_stab", int'(dut4.stab), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (8) step(5'b11100);

        repeat (40) begin
            v = 5'($urandom_range(0, 31));
            repeat ($urandom_range(1, 6)) step(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mof_source.md
MOF_SOURCE -- requirements
Module: mof_source

Interface
REQ-001 Parameter FILTER_CYCLES, default 4, number of consecutive clock edges the new majority value must persist before led changes; legal range 1..15.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 sw  input  5  voter inputs sw[4:0], asynchronous to clk, any value 0..31.
REQ-005 led  output  1  filtered majority-of-five result, registered.
REQ-006 count  output  3  registered population count of the sampled sw, 0..5.
REQ-007 unanimous  output  1  high when all five sampled inputs are equal (count 0 or 5).

Function
REQ-008 Sampling stage: count SHALL load popcount(sw) on every rising clk edge; latency 1 edge (without MOF_SYNC_EN).
REQ-009 Raw majority maj SHALL be combinational from count: maj = 1 when count >= 3, else 0; sw=0..31 covers every pattern, e.g. 5'b00111 -> 1, 5'b11000 -> 0.
REQ-010 unanimous SHALL be combinational from count: 1 iff count == 0 or count == 5.
REQ-011 Stability filter: 4-bit counter stab; on each edge, if maj == led then stab <= 0.
REQ-012 If maj != led and stab < FILTER_CYCLES-1, stab SHALL increment and led SHALL hold.
REQ-013 If maj != led and stab == FILTER_CYCLES-1, led SHALL load maj and stab SHALL clear, same edge.
REQ-014 Net latency: stable sw change reaches count at edge 0 and led at edge FILTER_CYCLES (FILTER_CYCLES+1 edges including the sampling edge).
REQ-015 Glitch rejection: any majority excursion shorter than FILTER_CYCLES edges SHALL leave led unchanged and clear stab when maj returns to led.
REQ-016 FILTER_CYCLES = 1: led SHALL follow maj with exactly one edge of delay, no filtering.
REQ-017 count and unanimous SHALL NOT be filtered; they track every sampled pattern.
REQ-018 stab SHALL never exceed FILTER_CYCLES-1; no wrap-around.

Reset
REQ-019 rst_n low SHALL immediately, without clk, force count = 0, led = 0, stab = 0 (hence unanimous = 1), and synchronizer flops (when present) = 0.
REQ-020 Reset asserted mid-filtering SHALL discard partial stab progress; after release, filtering restarts from stab = 0 against led = 0.
REQ-021 First rising edge with rst_n high SHALL perform normal sampling.

Configuration
REQ-022 Macro MOF_SYNC_EN defined: sw SHALL pass through a two-flop synchronizer (per bit) before the popcount register, adding exactly 2 edges to count, unanimous and led latency.
REQ-023 MOF_SYNC_EN undefined: sw feeds the popcount register directly; latencies as in REQ-008/REQ-014.

Verification
REQ-024 Reset: rst_n=0 with sw=5'b11111 -> count=0, led=0, unanimous=1 without any clk edge.
REQ-025 Exhaustive sweep, FILTER_CYCLES=1: sw=0..31, each held 10 edges -> count=popcount(sw), led=1 exactly for the 16 patterns with >=3 ones, unanimous only at 0 and 31.
REQ-026 Filter, FILTER_CYCLES=4: sw 0 -> 5'b01011 held -> led rises exactly at edge 4 after sampling edge; count=3 at edge 0.
REQ-027 Glitch, FILTER_CYCLES=4: led=1, sw=5'b00001 for 3 edges then 5'b11111 -> led stays 1, stab returns to 0.
REQ-028 Reset mid-filter: led=0, sw=5'b11100, rst_n pulsed low after 2 edges -> led=0, after release led rises 4 edges after re-sampling.
REQ-029 MOF_SYNC_EN defined, FILTER_CYCLES=1: sw 0 -> 31 -> count=5 two edges later than without macro, led three edges after sw change.
